// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, default widths and fetch FSM encodings.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 16-bit event counter used for fetch performance statistics.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ready handshake, IR and redirect/flush.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  discard_addr;
  logic               consume;
  logic               redirect;
  logic               capture;
  logic               drop;

  assign consume  = instr_valid && !stall;
  assign redirect = consume && pc_src;
  assign capture  = (state_q == S_REQ) && imem_req && imem_ready && !redirect;
  assign drop     = (state_q == S_DISCARD) && imem_ready;
  assign opcode   = instr_valid ? instr[INSTR_W-1 -: 4] : OP_NOP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // A request once raised is remembered in pending_q so stall cannot withdraw it.
  always_comb begin
    state_d   = state_q;
    pending_d = 1'b0;
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req  = pending_q || !instr_valid || !stall;
        pending_d = imem_req && !imem_ready && !redirect;
        if (redirect && imem_req && !imem_ready) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discard_addr;
        if (imem_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // discard_addr keeps the wrong-path address visible until memory accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
      instr_valid  <= 1'b0;
      instr        <= '0;
      pc           <= '0;
    end else if (redirect) begin
      fetch_pc     <= branch_target;
      discard_addr <= fetch_pc;
      instr_valid  <= 1'b0;
    end else if (capture) begin
      instr        <= imem_rdata;
      pc           <= fetch_pc;
      instr_valid  <= 1'b1;
      fetch_pc     <= fetch_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else if (consume) begin
      instr_valid  <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture),
    .count (perf_fetch_cnt)
  );

  fetch_perf_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect || drop),
    .count (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (addr-indexed combinational memory).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        pc_src;
  logic [7:0]  branch_target;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int checks;
  int errors;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (a == 8'h02) return 16'h7123;
    return {a[3:0], 4'h0, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 8'h00;
    repeat (3) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc got=%h exp=00", pc); end
    checks++; if (opcode !== 4'hF) begin errors++; $display("FAIL rst_opcode got=%h exp=f", opcode); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetch_cnt !== 16'h0 || perf_flush_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
`endif
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    tick();
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'(i)) begin
        errors++; $display("FAIL fetch_addr[%0d] got=%b/%h exp=1/%h", i, imem_req, imem_addr, 8'(i)); end
      if (i == 0) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid0 got=%b exp=0", instr_valid); end
      end else begin
        checks++; if (instr_valid !== 1'b1 || pc !== 8'(i - 1) || instr !== mem_word(8'(i - 1))) begin
          errors++; $display("FAIL fetch_ir[%0d] got=%b/%h/%h exp=1/%h/%h", i, instr_valid, pc, instr,
                             8'(i - 1), mem_word(8'(i - 1))); end
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) begin
      stall = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got=%b exp=0", k, imem_req); end
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h7123 || opcode !== 4'h7 || pc !== 8'h02) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%h exp=1/7123/7/02", k, instr_valid, instr, opcode, pc); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h03 || pc !== 8'h02) begin
      errors++; $display("FAIL stall_release got=%b/%h/%h exp=1/03/02", imem_req, imem_addr, pc); end
    tick();
    checks++; if (pc !== 8'h03 || instr !== mem_word(8'h03) || imem_addr !== 8'h04) begin
      errors++; $display("FAIL stall_nolose got=%h/%h/%h exp=03/%h/04", pc, instr, imem_addr, mem_word(8'h03)); end
    tick();
  endtask

  task automatic test_wait_state();
    checks++; if (imem_addr !== 8'h05 || pc !== 8'h04) begin
      errors++; $display("FAIL wait_start got=%h/%h exp=05/04", imem_addr, pc); end
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
        errors++; $display("FAIL wait_hold[%0d] got=%b/%h exp=1/05", k, imem_req, imem_addr); end
      if (k > 0) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got=%b exp=0", k, instr_valid); end
      end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h05 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL wait_accept got=%b/%h/%b exp=1/05/0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || pc !== 8'h05 || instr !== mem_word(8'h05)) begin
      errors++; $display("FAIL wait_capture got=%b/%h/%h exp=1/05/%h", instr_valid, pc, instr, mem_word(8'h05)); end
  endtask

  task automatic test_redirect_capture();
    checks++; if (imem_addr !== 8'h06) begin errors++; $display("FAIL redir_addr6 got=%h exp=06", imem_addr); end
    pc_src = 1'b1; branch_target = 8'h40;
    #1;
    tick();
    pc_src = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0 || opcode !== 4'hF) begin
      errors++; $display("FAIL redir_flush got=%b/%h/%b/%h exp=1/40/0/f", imem_req, imem_addr, instr_valid, opcode); end
    tick();
    checks++; if (instr_valid !== 1'b1 || pc !== 8'h40 || instr !== mem_word(8'h40) || imem_addr !== 8'h41) begin
      errors++; $display("FAIL redir_target got=%b/%h/%h/%h exp=1/40/%h/41", instr_valid, pc, instr, imem_addr,
                         mem_word(8'h40)); end
  endtask

  task automatic test_redirect_pending();
    pc_src = 1'b1; branch_target = 8'h06;
    #1;
    tick();
    pc_src = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h06) begin errors++; $display("FAIL pend_addr6 got=%h exp=06", imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || pc !== 8'h06 || imem_addr !== 8'h07) begin
      errors++; $display("FAIL pend_setup got=%b/%h/%h exp=1/06/07", instr_valid, pc, imem_addr); end
    imem_ready = 1'b0; pc_src = 1'b1; branch_target = 8'h40;
    #1;
    tick();
    pc_src = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h07 || instr_valid !== 1'b0 || opcode !== 4'hF) begin
      errors++; $display("FAIL pend_discard got=%b/%h/%b/%h exp=1/07/0/f", imem_req, imem_addr, instr_valid, opcode); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h07) begin
      errors++; $display("FAIL pend_hold got=%b/%h exp=1/07", imem_req, imem_addr); end
    imem_ready = 1'b1;
    #1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL pend_drop got=%b/%h/%b exp=1/40/0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || pc !== 8'h40 || instr !== mem_word(8'h40)) begin
      errors++; $display("FAIL pend_target got=%b/%h/%h exp=1/40/%h", instr_valid, pc, instr, mem_word(8'h40)); end
  endtask

  task automatic test_wrap();
    pc_src = 1'b1; branch_target = 8'hFE;
    #1;
    tick();
    pc_src = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_fe got=%h exp=fe", imem_addr); end
    tick();
    checks++; if (imem_addr !== 8'hFF || pc !== 8'hFE) begin
      errors++; $display("FAIL wrap_ff got=%h/%h exp=ff/fe", imem_addr, pc); end
    stall = 1'b1; pc_src = 1'b1; branch_target = 8'h10;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_stallreq got=%b exp=0", imem_req); end
    tick();
    stall = 1'b0; pc_src = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || pc !== 8'hFE || imem_addr !== 8'hFF) begin
      errors++; $display("FAIL redir_ignored got=%b/%h/%h exp=1/fe/ff", instr_valid, pc, imem_addr); end
    tick();
    checks++; if (pc !== 8'hFF || imem_addr !== 8'h00) begin
      errors++; $display("FAIL wrap_00 got=%h/%h exp=ff/00", pc, imem_addr); end
    tick();
    checks++; if (pc !== 8'h00 || imem_addr !== 8'h01 || instr !== mem_word(8'h00)) begin
      errors++; $display("FAIL wrap_cap got=%h/%h/%h exp=00/01/%h", pc, imem_addr, instr, mem_word(8'h00)); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_flush_cnt !== 16'd5) begin
      errors++; $display("FAIL perf_flush got=%0d exp=5", perf_flush_cnt); end
`endif
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_saturate();
    rst_n = 1'b0;
    tick();
    checks++; if (perf_fetch_cnt !== 16'h0 || perf_flush_cnt !== 16'h0) begin
      errors++; $display("FAIL perf_rst got=%h/%h exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
    rst_n = 1'b1;
    repeat (70002) tick();
    checks++; if (perf_fetch_cnt !== 16'hFFFF || perf_flush_cnt !== 16'h0) begin
      errors++; $display("FAIL perf_sat got=%h/%h exp=ffff/0000", perf_fetch_cnt, perf_flush_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 8'h00;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_wait_state();
    test_redirect_capture();
    test_redirect_pending();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control unit and the register-file/immediate decode.
- Holds the program counter and issues requests to instruction memory over a req/ready handshake.
- Latches each returned word into an instruction register (IR) and presents `opcode`, `instr` and `pc` downstream.
- Accepts `pc_src`/`branch_target` redirects from execute, flushes wrong-path words, and holds its output under `stall`.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 16, instruction width; opcode is `instr[INSTR_W-1 -: 4]`.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while `imem_req` is high and `imem_ready` is low.
- imem_rdata  in  INSTR_W  instruction word; valid in the cycle where `imem_req && imem_ready`.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- stall  in  1  downstream cannot consume the IR this cycle.
- pc_src  in  1  branch taken; the control unit's PCSrc after execute qualification.
- branch_target  in  ADDR_W  redirect address.
- instr_valid  out  1  IR holds a live instruction.
- instr  out  INSTR_W  IR contents.
- opcode  out  4  `instr[INSTR_W-1 -: 4]` when `instr_valid`, else OP_NOP (4'b1111).
- pc  out  ADDR_W  address of the instruction in the IR.

Behaviour:
- Reset values: `fetch_pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `pc`=0, `opcode`=OP_NOP, state=S_IDLE.
  - Reset mid-transaction abandons the request; memory must tolerate `imem_req` dropping.
- FSM states and transitions:
  - S_IDLE: one cycle after reset release, then S_REQ.
  - S_REQ: `imem_req` = `!instr_valid || !stall` (IR free or being consumed this cycle); `imem_addr`=`fetch_pc`.
  - S_DISCARD: `imem_req`=1 with the old address held; on `imem_ready`, drop `imem_rdata` and go to S_REQ with the new `fetch_pc`.
- Handshake: once `imem_req` is asserted, it and `imem_addr` stay constant until `imem_ready`.
  - Therefore `imem_req` is evaluated as a registered decision: raised only when the IR-free condition holds, never withdrawn until accepted.
  - While a request is pending and the IR is full, `stall` has no effect on the pending request.
- Capture (`imem_req && imem_ready` in S_REQ, no redirect): IR<=`imem_rdata`, `pc`<=`fetch_pc`, `instr_valid`<=1, `fetch_pc`<=`fetch_pc`+1 (wraps modulo 2^ADDR_W, 0xFF->0x00 at default).
  - Latency: data returned in cycle N is visible on `instr`/`opcode` in cycle N+1.
  - Zero-wait memory sustains one instruction per cycle.
- Consume: `instr_valid && !stall`. If there is no same-cycle capture, `instr_valid`<=0.
  - Consume plus capture in the same cycle gives back-to-back valid output.
- Stall: `instr_valid`, `instr`, `pc` and `opcode` held bit-exact.
- Redirect: `pc_src` is honoured only when `instr_valid && !stall`; ignored otherwise. On redirect:
  - `fetch_pc`<=`branch_target`, `instr_valid`<=0 (flush).
  - Any same-cycle captured word is discarded.
  - If a request is pending but not ready, go to S_DISCARD; else stay in S_REQ.
- Redirect while in S_DISCARD cannot happen, because the IR is invalid there.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs `perf_fetch_cnt[15:0]`, which counts IR captures.
  - Adds outputs `perf_flush_cnt[15:0]`, which counts redirects plus S_DISCARD drops.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header `cpu_pkg`: OP_NOP=4'b1111, opcode field position, ADDR_W/INSTR_W defaults, FSM state encodings (S_IDLE=2'd0, S_REQ=2'd1, S_DISCARD=2'd2).
- One sub-module `fetch_perf_counter` (saturating 16-bit counter with increment enable), instantiated twice under FETCH_PERF_CNT_EN.
- PC/IR/FSM stay in the top module.

Test Plan:
- Reset release, `imem_ready`=1 always, `imem_rdata`=addr-indexed words:
  - `imem_addr` 0,1,2,3 on consecutive cycles.
  - `instr_valid` rises 2 cycles after reset release.
  - `pc` follows one cycle behind.
- `imem_ready` low for 3 cycles on addr 5 → `imem_req`/`imem_addr`=5 held constant; `instr_valid`=0 for those cycles; capture on the 4th.
- `stall`=1 for 4 cycles with IR=16'h7123 at pc 2:
  - `instr`/`opcode`=4'h7/`pc` unchanged.
  - At most one further request issued, held until ready.
  - No word lost after `stall` falls.
- Redirect `pc_src`=1, target 8'h40, same cycle as a ready capture of addr 6 → word 6 dropped; next `imem_addr`=8'h40; `opcode`=OP_NOP for one cycle.
- Redirect while the addr 7 request is pending (`imem_ready`=0) → S_DISCARD, addr 7 held; on ready its data is dropped; next request addr 8'h40.
- `fetch_pc` at 8'hFF → next request 8'h00. With FETCH_PERF_CNT_EN, 70000 captures → `perf_fetch_cnt`=16'hFFFF.
